// File: rtl/serial_tx_pkg.sv
// Shared types and line levels for the serial byte transmitter.
package serial_tx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;

endpackage

// File: rtl/serial_baud_tick.sv
// Bit-boundary tick generator: counts 0..CLKS_PER_BIT-1 while running and
// pulses tick on the last cycle of each bit.
module serial_baud_tick #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    input  logic run,
    output logic tick
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (restart || !run || (cnt_q == CNT_LAST)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = run && !restart && (cnt_q == CNT_LAST);

endmodule

// File: rtl/serial_byte_tx.sv
// Serial byte transmitter with a holding register in front of the shifter.
// Define SERIAL_TX_PARITY_EN to insert an even parity bit after the data bits.
//
// state  | meaning
// IDLE   | line idle high, waiting for the holding register to fill
// START  | start bit (low)
// DATA   | data bits, LSB first
// PARITY | even parity bit (parity build only)
// STOP   | stop bit (high); tx_done on its last cycle
module serial_byte_tx
    import serial_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4,
    parameter int DATA_W       = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              tx_out,
    output logic              tx_busy,
    output logic              tx_done
);

    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

    tx_state_e         state_q, state_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic              hold_full_q, hold_full_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
`ifdef SERIAL_TX_PARITY_EN
    logic              parity_q, parity_d;
`endif

    logic tick;
    logic accept;
    logic load;
    logic restart;
    logic bit_last;

    assign tx_ready = !hold_full_q;
    assign accept   = tx_valid && tx_ready;
    assign bit_last = (bit_cnt_q == BIT_LAST);
    assign restart  = (state_q == IDLE) && hold_full_q;
    // The shifter takes the waiting byte either from idle or seamlessly at the end of a stop bit.
    assign load     = restart || ((state_q == STOP) && tick && hold_full_q);

    serial_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_tick (
        .clk     (clk),
        .rst     (rst),
        .restart (restart),
        .run     (state_q != IDLE),
        .tick    (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (hold_full_q) state_d = START;
            START: if (tick) state_d = DATA;
            DATA: begin
                if (tick && bit_last) begin
`ifdef SERIAL_TX_PARITY_EN
                    state_d = PARITY;
`else
                    state_d = STOP;
`endif
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            PARITY: if (tick) state_d = STOP;
`endif
            STOP:  if (tick) state_d = hold_full_q ? START : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        tx_out  = IDLE_LEVEL;
        tx_busy = 1'b1;
        tx_done = 1'b0;
        case (state_q)
            IDLE:   tx_busy = 1'b0;
            START:  tx_out  = START_LEVEL;
            DATA:   tx_out  = shift_q[0];
`ifdef SERIAL_TX_PARITY_EN
            PARITY: tx_out  = parity_q;
`endif
            STOP: begin
                tx_out  = STOP_LEVEL;
                tx_done = tick;
            end
            default: tx_busy = 1'b0;
        endcase
    end

    // A same-cycle accept and load would write the new byte while the old one moves on.
    always_comb begin
        hold_d      = accept ? tx_data : hold_q;
        hold_full_d = accept || (hold_full_q && !load);
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        if (load) begin
            shift_d   = hold_q;
            bit_cnt_d = '0;
        end else if ((state_q == DATA) && tick) begin
            shift_d   = shift_q >> 1;
            bit_cnt_d = bit_last ? '0 : bit_cnt_q + 1'b1;
        end
    end

`ifdef SERIAL_TX_PARITY_EN
    always_comb begin
        parity_d = load ? ^hold_q : parity_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
        end else begin
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
        end
    end

endmodule

// File: tb/tb_serial_byte_tx.sv
// Self-checking bench for serial_byte_tx: directed frames plus random streams
// checked against a frame-level line model (both parity builds).
module tb_serial_byte_tx;

`ifdef SERIAL_TX_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif
    localparam int NBITS = 10 + PAR_BITS;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] d_a, d_b;
    logic       v_a, v_b;
    logic       rdy_a, out_a, busy_a, done_a;
    logic       rdy_b, out_b, busy_b, done_b;
    logic       sel_b;
    logic       m_rdy, m_out, m_busy, m_done;

    int         n_chk = 0;
    int         n_err = 0;
    int         max_gap = 0;
    int         done_cnt = 0;
    logic [7:0] stim[$];

    serial_byte_tx #(.CLKS_PER_BIT(4), .DATA_W(8)) u_dut_a (
        .clk(clk), .rst(rst), .tx_data(d_a), .tx_valid(v_a),
        .tx_ready(rdy_a), .tx_out(out_a), .tx_busy(busy_a), .tx_done(done_a)
    );

    serial_byte_tx #(.CLKS_PER_BIT(2), .DATA_W(8)) u_dut_b (
        .clk(clk), .rst(rst), .tx_data(d_b), .tx_valid(v_b),
        .tx_ready(rdy_b), .tx_out(out_b), .tx_busy(busy_b), .tx_done(done_b)
    );

    always #5 clk = ~clk;

    assign m_rdy  = sel_b ? rdy_b  : rdy_a;
    assign m_out  = sel_b ? out_b  : out_a;
    assign m_busy = sel_b ? busy_b : busy_a;
    assign m_done = sel_b ? done_b : done_a;

    always @(negedge clk) if (m_done === 1'b1) done_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Expected line level for bit slot idx of a frame carrying d.
    function automatic logic exp_bit(input logic [7:0] d, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return d[idx-1];
        if (PAR_BITS == 1 && idx == 9) return ^d;
        return 1'b1;
    endfunction

    task automatic put(input logic v, input logic [7:0] d);
        if (sel_b) begin v_b = v; d_b = d; end
        else begin v_a = v; d_a = d; end
    endtask

    // Offers stim[] in order, holding valid and data until each handshake; entered at a negedge.
    task automatic drive();
        int t, gap;
        foreach (stim[i]) begin
            gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
            repeat (gap) begin
                put(1'b0, 8'($urandom));
                @(negedge clk);
            end
            put(1'b1, stim[i]);
            t = 0;
            while (m_rdy !== 1'b1 && t < 200) begin
                @(negedge clk);
                t++;
            end
            chk("hs_wait", 32'(t < 200), 1);
            @(posedge clk);
            @(negedge clk);
        end
        put(1'b0, 8'($urandom));
    endtask

    // Cycle-exact check of n back-to-back frames; the first handshake is on the next posedge.
    task automatic check_stream(input string tag, input int cpb, input int n);
        int fl, f, off;
        fl = cpb * NBITS;
        @(posedge clk);
        for (int c = 1; c <= n * fl; c++) begin
            @(posedge clk);
            @(negedge clk);
            f   = (c - 1) / fl;
            off = (c - 1) % fl;
            chk({tag, "_out"},  32'(m_out),  32'(exp_bit(stim[f], off / cpb)));
            chk({tag, "_done"}, 32'(m_done), 32'(off == fl - 1));
            chk({tag, "_busy"}, 32'(m_busy), 1);
            chk({tag, "_rdy"},  32'(m_rdy),  32'(!((f + 1 < n) && (off >= 1))));
        end
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_idle_out"},  32'(m_out),  1);
        chk({tag, "_idle_busy"}, 32'(m_busy), 0);
        chk({tag, "_idle_rdy"},  32'(m_rdy),  1);
    endtask

    // Frame decoder for streams with arbitrary gaps: each frame must carry stim[k] in order.
    task automatic receive(input string tag, input int cpb, input int n);
        int t, good, dn, bz;
        for (int k = 0; k < n; k++) begin
            t = 0;
            while (m_out !== 1'b0 && t < 400) begin
                @(negedge clk);
                t++;
            end
            chk({tag, "_start_wait"}, 32'(t < 400), 1);
            if (t >= 400) return;
            good = 0; dn = 0; bz = 0;
            for (int b = 0; b < NBITS; b++) begin
                for (int j = 0; j < cpb; j++) begin
                    if (b != 0 || j != 0) @(negedge clk);
                    if (m_out === exp_bit(stim[k], b)) good++;
                    if (m_done === ((b == NBITS - 1) && (j == cpb - 1))) dn++;
                    if (m_busy === 1'b1) bz++;
                end
            end
            chk({tag, "_bits"}, good, NBITS * cpb);
            chk({tag, "_done"}, dn,   NBITS * cpb);
            chk({tag, "_busy"}, bz,   NBITS * cpb);
            @(negedge clk);
        end
    endtask

    task automatic run_random(input string tag, input bit use_b, input int cpb, input int n);
        sel_b   = use_b;
        max_gap = 3 * cpb;
        stim.delete();
        repeat (n) stim.push_back(8'($urandom_range(0, 255)));
        done_cnt = 0;
        fork
            drive();
            receive(tag, cpb, n);
        join
        repeat (3) @(negedge clk);
        chk({tag, "_done_cnt"}, done_cnt, n);
        chk({tag, "_end_out"},  32'(m_out),  1);
        chk({tag, "_end_busy"}, 32'(m_busy), 0);
        max_gap = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; sel_b = 1'b0;
        v_a = 1'b0; v_b = 1'b0; d_a = 8'h00; d_b = 8'h00;
        repeat (2) @(negedge clk);
        chk("rst_out_a",  32'(out_a),  1);
        chk("rst_rdy_a",  32'(rdy_a),  1);
        chk("rst_busy_a", 32'(busy_a), 0);
        chk("rst_done_a", 32'(done_a), 0);
        chk("rst_out_b",  32'(out_b),  1);
        chk("rst_rdy_b",  32'(rdy_b),  1);

        // Handshake on the very first edge after reset release.
        @(negedge clk);
        rst  = 1'b0;
        stim = '{8'hA5};
        fork drive(); check_stream("a5", 4, 1); join

        stim = '{8'h01, 8'h80};
        fork drive(); check_stream("b2b", 4, 2); join

        stim = '{8'h5A, 8'hC3, 8'h96};
        fork drive(); check_stream("bp3", 4, 3); join

        stim = '{8'h07, 8'h03};
        fork drive(); check_stream("par", 4, 2); join

        stim = '{8'hFF};
        fork
            drive();
            begin
                @(posedge clk);
                repeat (17) @(posedge clk);
                #2 rst = 1'b1;
                #1;
                chk("rst17_out",  32'(m_out),  1);
                chk("rst17_rdy",  32'(m_rdy),  1);
                chk("rst17_busy", 32'(m_busy), 0);
                chk("rst17_done", 32'(m_done), 0);
            end
        join
        @(negedge clk);
        rst = 1'b0;

        // Reset during the start bit with a second byte already held: both must vanish.
        stim = '{8'h3C, 8'h55};
        fork
            drive();
            begin
                @(posedge clk);
                repeat (2) @(posedge clk);
                #2;
                chk("rst2_pre_out", 32'(m_out), 0);
                chk("rst2_pre_rdy", 32'(m_rdy), 0);
                rst = 1'b1;
                #1;
                chk("rst2_out", 32'(m_out), 1);
                chk("rst2_rdy", 32'(m_rdy), 1);
            end
        join
        repeat (2) @(negedge clk);
        chk("rst2_hold_out", 32'(m_out), 1);
        rst = 1'b0;
        stim = '{8'h00};
        fork drive(); check_stream("post_rst", 4, 1); join

        sel_b = 1'b1;
        stim  = '{8'h00};
        fork drive(); check_stream("cpb2_00", 2, 1); join
        stim  = '{8'hA5, 8'hF0};
        fork drive(); check_stream("cpb2_b2b", 2, 2); join

        run_random("rnd_a", 1'b0, 4, 16);
        run_random("rnd_b", 1'b1, 2, 16);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
